// File: rtl/alu_flag_unit_pkg.sv
// ---- alu_pkg : shared ALU op codes, A64 condition codes, branch kinds, NZCV indices -- rev 1.0 ----
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  // Bit positions inside the packed {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_CBNZ   = 2'b10,
    BR_UNCOND = 2'b11
  } br_kind_e;

endpackage

`default_nettype wire

// File: rtl/alu_flag_unit_cond_eval.sv
// ---- cond_eval : combinational A64 condition-code check against an NZCV vector -- rev 1.0 ----
`default_nettype none

module cond_eval
  import alu_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = nzcv[FLAG_N];
    z    = nzcv[FLAG_Z];
    c    = nzcv[FLAG_C];
    v    = nzcv[FLAG_V];
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !(c & !z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = !(!z & (n == v));
      default: pass = 1'b1;  // AL and NV both always pass in A64
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_flag_unit.sv
// ---- alu_flag_unit : NZCV flag register plus registered branch taken/not-taken decision -- rev 1.0 ----
`default_nettype none

module alu_flag_unit
  import alu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] alu_cntrl,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic       set_flags,
  input  logic       q_valid,
  input  logic [1:0] q_kind,
  input  logic [3:0] q_cond,
  input  logic       flush,
  output logic [3:0] flags_q,
  output logic       taken_valid,
  output logic       taken
);

  logic [3:0] flags_d;
  logic       taken_valid_d, taken_valid_q;
  logic       taken_d, taken_q;
  logic       cond_pass;
  logic       result;

  // flags_d doubles as the bypass value: it already holds this cycle's write
  cond_eval u_cond_eval (
    .cond (cond_e'(q_cond)),
    .nzcv (flags_d),
    .pass (cond_pass)
  );

  always_comb begin
    flags_d = flags_q;
    if (set_flags) begin
      case (alu_cntrl)
        ALU_ADD, ALU_SUBTRACT: flags_d = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        ALU_AND:               flags_d = {alu_negative, alu_zero, 2'b00};
        default:               flags_d = flags_q;
      endcase
    end
  end

  always_comb begin
    result = 1'b1;
    case (br_kind_e'(q_kind))
      BR_COND:  result = cond_pass;
      BR_CBZ:   result = alu_zero;
      BR_CBNZ:  result = !alu_zero;
      default:  result = 1'b1;
    endcase
    taken_valid_d = q_valid & !flush;
    taken_d       = taken_valid_d ? result : taken_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q       <= RESET_FLAGS;
      taken_valid_q <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      taken_valid_q <= taken_valid_d;
      taken_q       <= taken_d;
    end
  end

  assign taken_valid = taken_valid_q;
  assign taken       = taken_q;

endmodule

`default_nettype wire
